network_output_schedule: RTL and testbench
==========================================

Name: network_output_schedule

Overview:
- Descriptor scheduler directly upstream of the network transmit stage. It buffers 61-bit packet descriptors in two priority FIFOs: time-sensitive (TS) and best-effort (BE).
- Issues one descriptor at a time to the transmit stage under the descriptor-ready handshake.
- Strict priority: TS first; BE is additionally gated by a gate-control input.
- Counts discards on full FIFOs and exports FIFO occupancy for debug.

Parameters:
- DEPTH, 16, entries per FIFO; must be a power of 2.
- AW, 4, address width, log2(DEPTH).

Ports:
- i_clk  in  1  core clock.
- i_rst_n  in  1  asynchronous active-low reset.
- iv_descriptor  in  61  incoming descriptor; bits [60:58] = packet type.
- i_descriptor_wr  in  1  one-cycle write strobe for iv_descriptor.
- i_be_gate  in  1  1 = BE queue may be scheduled.
- i_pkt_descriptor_ready  in  1  transmit stage can accept a descriptor (level).
- ov_pkt_descriptor  out  61  descriptor to the transmit stage.
- o_pkt_descriptor_wr  out  1  one-cycle valid strobe for ov_pkt_descriptor.
- o_ts_discard_pulse  out  1  TS descriptor dropped (FIFO full).
- o_be_discard_pulse  out  1  BE descriptor dropped (FIFO full).
- ov_ts_cnt  out  AW+1  TS FIFO occupancy.
- ov_be_cnt  out  AW+1  BE FIFO occupancy.
- ov_sch_state  out  2  FSM state, for debug.

Behaviour:
- Reset (asynchronous, active-low): i_rst_n, applied asynchronously, clock i_clk. All outputs are 0; FIFO pointers and counts are 0; FSM is in IDLE.
- Reset mid-operation: pending descriptors are lost and any strobe in progress deasserts immediately.
- Classification:
  - Type iv_descriptor[60:58] <= 3'h2 goes to the TS FIFO.
  - Any other type goes to the BE FIFO.
  - Evaluated in the cycle i_descriptor_wr = 1.
- Enqueue:
  - If the target FIFO count is below DEPTH, write at wr_ptr, then wr_ptr+1 (wraps modulo DEPTH) and count+1.
  - If the target FIFO is full, the descriptor is dropped. The matching discard pulse is 1 for exactly the next cycle. Pointers and count are unchanged.
- FSM states: IDLE=2'd0, ISSUE=2'd1, HOLD=2'd2.
  - IDLE: at the clock edge where i_pkt_descriptor_ready=1 and (ts_cnt != 0 or (be_cnt != 0 and i_be_gate=1)):
    - Register the head of the selected FIFO into ov_pkt_descriptor and set o_pkt_descriptor_wr=1.
    - Pop that FIFO: rd_ptr+1, count-1.
    - Go to ISSUE.
    - TS always wins over BE.
  - ISSUE: o_pkt_descriptor_wr=1 for this single cycle. At the next edge, o_pkt_descriptor_wr goes to 0 and the FSM goes to HOLD.
  - HOLD: waits one cycle so the downstream ready can fall, then goes to IDLE unconditionally.
  - Resulting rate: at most one descriptor per 3 cycles.
- ov_pkt_descriptor holds its last value while o_pkt_descriptor_wr=0.
- Latency: a write into an empty FIFO, with ready=1 and FSM in IDLE, gives o_pkt_descriptor_wr=1 two cycles after the write cycle.
- Simultaneous enqueue and pop on the same FIFO: the count is unchanged and both pointers advance.
  - A full FIFO that is popped in the same cycle still drops the incoming descriptor; full is judged on the pre-edge count.
  - Writing to an empty FIFO does not bypass it; the descriptor cannot be popped in the same cycle.
- i_be_gate=0 blocks only BE scheduling. BE enqueue continues, and the gate does not affect a descriptor already issued.
- Ready low in IDLE: the FSM stays in IDLE and the FIFOs hold their contents.
- ov_ts_cnt and ov_be_cnt are registered occupancies, range 0..DEPTH.

Test Plan:
1. Reset with both FIFOs empty, ready=1 -> all outputs 0, ov_sch_state=0, and no wr strobe for 20 cycles.
2. Write one descriptor with type=3'h1, ready=1 -> o_pkt_descriptor_wr=1 two cycles later with identical 61 bits; ov_ts_cnt goes 1 then 0.
3. Write BE (type=3'h5) then TS (type=3'h0) back-to-back while ready=0, then raise ready -> TS is issued first; BE follows 3 cycles later.
4. Write 17 TS descriptors while ready=0 -> ov_ts_cnt=16 and one o_ts_discard_pulse; after draining, exactly 16 are issued in FIFO order with pointers wrapping correctly.
5. Put 3 entries in the BE FIFO with i_be_gate=0 and ready=1 -> no issue; raise the gate -> 3 strobes, spaced 3 cycles apart.
6. Assert reset while in ISSUE with 5 entries queued -> wr drops immediately and counts are 0; after release, no strobe appears without new writes.

Source files
------------

// File: rtl/network_output_schedule.sv
// Descriptor scheduler feeding the network transmit stage.
// Two FIFOs hold 61-bit descriptors: time-sensitive (types 0..2) and best-effort
// (all other types). A three-state FSM issues at most one descriptor every three
// cycles. TS has strict priority. BE is also gated by i_be_gate.
module network_output_schedule #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [60:0]   iv_descriptor,
    input  logic          i_descriptor_wr,
    input  logic          i_be_gate,
    input  logic          i_pkt_descriptor_ready,
    output logic [60:0]   ov_pkt_descriptor,
    output logic          o_pkt_descriptor_wr,
    output logic          o_ts_discard_pulse,
    output logic          o_be_discard_pulse,
    output logic [AW:0]   ov_ts_cnt,
    output logic [AW:0]   ov_be_cnt,
    output logic [1:0]    ov_sch_state
);

    localparam logic [1:0]    IDLE     = 2'd0;
    localparam logic [1:0]    ISSUE    = 2'd1;
    localparam logic [1:0]    HOLD     = 2'd2;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [60:0]   tsMem [DEPTH];
    logic [60:0]   beMem [DEPTH];

    logic [AW-1:0] tsWrPtr_q, tsRdPtr_q, beWrPtr_q, beRdPtr_q;
    logic [AW:0]   tsCnt_q, tsCnt_d, beCnt_q, beCnt_d;
    logic [1:0]    state_q, state_d;
    logic [60:0]   desc_q, desc_d;
    logic          descWr_q, descWr_d;
    logic          tsDiscard_q, tsDiscard_d, beDiscard_q, beDiscard_d;

    logic          isTs, tsFull, beFull;
    logic          tsPush, bePush, tsPop, bePop;

    // Classify the incoming descriptor and decide push or drop against the pre-edge counts
    always_comb begin
        isTs        = (iv_descriptor[60:58] <= 3'h2);
        tsFull      = (tsCnt_q == FULL_LVL);
        beFull      = (beCnt_q == FULL_LVL);
        tsPush      = i_descriptor_wr &  isTs & ~tsFull;
        bePush      = i_descriptor_wr & ~isTs & ~beFull;
        tsDiscard_d = i_descriptor_wr &  isTs &  tsFull;
        beDiscard_d = i_descriptor_wr & ~isTs &  beFull;
    end

    // Scheduler FSM: pick a FIFO head in IDLE, strobe for one cycle, then hold one cycle
    always_comb begin
        state_d  = state_q;
        desc_d   = desc_q;
        descWr_d = 1'b0;
        tsPop    = 1'b0;
        bePop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_pkt_descriptor_ready) begin
                    if (tsCnt_q != '0) begin
                        tsPop    = 1'b1;
                        desc_d   = tsMem[tsRdPtr_q];
                        descWr_d = 1'b1;
                        state_d  = ISSUE;
                    end else if ((beCnt_q != '0) && i_be_gate) begin
                        bePop    = 1'b1;
                        desc_d   = beMem[beRdPtr_q];
                        descWr_d = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE:   state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Occupancy bookkeeping: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        tsCnt_d = tsCnt_q;
        beCnt_d = beCnt_q;
        if (tsPush && !tsPop) begin
            tsCnt_d = tsCnt_q + CNT_ONE;
        end else if (!tsPush && tsPop) begin
            tsCnt_d = tsCnt_q - CNT_ONE;
        end
        if (bePush && !bePop) begin
            beCnt_d = beCnt_q + CNT_ONE;
        end else if (!bePush && bePop) begin
            beCnt_d = beCnt_q - CNT_ONE;
        end
    end

    // Descriptor storage; contents need no reset because occupancy guards every read
    always_ff @(posedge i_clk) begin
        if (tsPush) begin
            tsMem[tsWrPtr_q] <= iv_descriptor;
        end
        if (bePush) begin
            beMem[beWrPtr_q] <= iv_descriptor;
        end
    end

    // Pointers, counts, FSM and output registers, all cleared by the asynchronous reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tsWrPtr_q   <= '0;
            tsRdPtr_q   <= '0;
            beWrPtr_q   <= '0;
            beRdPtr_q   <= '0;
            tsCnt_q     <= '0;
            beCnt_q     <= '0;
            state_q     <= IDLE;
            desc_q      <= '0;
            descWr_q    <= 1'b0;
            tsDiscard_q <= 1'b0;
            beDiscard_q <= 1'b0;
        end else begin
            if (tsPush) tsWrPtr_q <= tsWrPtr_q + PTR_ONE;
            if (tsPop)  tsRdPtr_q <= tsRdPtr_q + PTR_ONE;
            if (bePush) beWrPtr_q <= beWrPtr_q + PTR_ONE;
            if (bePop)  beRdPtr_q <= beRdPtr_q + PTR_ONE;
            tsCnt_q     <= tsCnt_d;
            beCnt_q     <= beCnt_d;
            state_q     <= state_d;
            desc_q      <= desc_d;
            descWr_q    <= descWr_d;
            tsDiscard_q <= tsDiscard_d;
            beDiscard_q <= beDiscard_d;
        end
    end

    assign ov_pkt_descriptor   = desc_q;
    assign o_pkt_descriptor_wr = descWr_q;
    assign o_ts_discard_pulse  = tsDiscard_q;
    assign o_be_discard_pulse  = beDiscard_q;
    assign ov_ts_cnt           = tsCnt_q;
    assign ov_be_cnt           = beCnt_q;
    assign ov_sch_state        = state_q;

endmodule

// File: tb/tb_network_output_schedule.sv
// Testbench for network_output_schedule: per-cycle vector table plus hand sequences
// for FIFO overflow and wrap, and reset in the middle of an issue.
module tb_network_output_schedule;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [60:0] DA = {3'h1, 58'h3FF_0000_ABCD};
    localparam logic [60:0] DB = {3'h5, 58'h111};
    localparam logic [60:0] DT = {3'h0, 58'h222};
    localparam logic [60:0] B1 = {3'h3, 58'h501};
    localparam logic [60:0] B2 = {3'h4, 58'h502};
    localparam logic [60:0] B3 = {3'h7, 58'h503};

    logic        clk;
    logic        rstN;
    logic [60:0] descIn;
    logic        descWrIn;
    logic        beGate;
    logic        ready;
    logic [60:0] descOut;
    logic        descWrOut;
    logic        tsDiscard;
    logic        beDiscard;
    logic [4:0]  tsCnt;
    logic [4:0]  beCnt;
    logic [1:0]  schState;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [60:0] desc;
        logic        gate;
        logic        rdy;
        logic [75:0] exp;
    } vec_t;

    vec_t vecs[$];

    network_output_schedule #(.DEPTH(16), .AW(4)) dut (
        .i_clk                  (clk),
        .i_rst_n                (rstN),
        .iv_descriptor          (descIn),
        .i_descriptor_wr        (descWrIn),
        .i_be_gate              (beGate),
        .i_pkt_descriptor_ready (ready),
        .ov_pkt_descriptor      (descOut),
        .o_pkt_descriptor_wr    (descWrOut),
        .o_ts_discard_pulse     (tsDiscard),
        .o_be_discard_pulse     (beDiscard),
        .ov_ts_cnt              (tsCnt),
        .ov_be_cnt              (beCnt),
        .ov_sch_state           (schState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] expv(input logic wr, input logic [60:0] d,
                                         input logic [4:0] ts, input logic [4:0] be,
                                         input logic [1:0] st, input logic tsd, input logic bed);
        return {wr, d, ts, be, st, tsd, bed};
    endfunction

    function automatic logic [75:0] actual();
        return {descWrOut, descOut, tsCnt, beCnt, schState, tsDiscard, beDiscard};
    endfunction

    function automatic void addVec(input logic wr, input logic [60:0] d, input logic g,
                                   input logic r, input logic [75:0] e);
        vec_t v;
        v.wr   = wr;
        v.desc = d;
        v.gate = g;
        v.rdy  = r;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one row at the falling edge, sample the result 1ns after the next rising edge
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        descWrIn = v.wr;
        descIn   = v.desc;
        beGate   = v.gate;
        ready    = v.rdy;
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d", idx), actual(), v.exp);
    endtask

    task automatic waitStrobe(output logic found);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (descWrOut) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    logic [60:0] tsExp [17];
    logic [60:0] firstT6;
    logic        found;
    int          extra;

    initial begin
        rstN     = 1'b0;
        descIn   = '0;
        descWrIn = 1'b0;
        beGate   = 1'b1;
        ready    = 1'b1;

        // Reset: outputs zero while held, then no strobe for 20 cycles with empty FIFOs
        repeat (3) @(negedge clk);
        checkOutput("reset_hold", actual(), '0);
        rstN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle_empty%0d", i), actual(), '0);
        end

        // Single TS write: strobe two cycles after the write, then back to IDLE
        addVec(1, DA, 1, 1, expv(0, '0, 5'd1, 5'd0, IDLE,  0, 0));
        addVec(0, '0, 1, 1, expv(1, DA, 5'd0, 5'd0, ISSUE, 0, 0));
        addVec(0, '0, 1, 1, expv(0, DA, 5'd0, 5'd0, HOLD,  0, 0));
        addVec(0, '0, 1, 1, expv(0, DA, 5'd0, 5'd0, IDLE,  0, 0));
        // BE then TS with ready low; TS wins, BE follows three cycles later
        addVec(1, DB, 1, 0, expv(0, DA, 5'd0, 5'd1, IDLE,  0, 0));
        addVec(1, DT, 1, 0, expv(0, DA, 5'd1, 5'd1, IDLE,  0, 0));
        addVec(0, '0, 1, 0, expv(0, DA, 5'd1, 5'd1, IDLE,  0, 0));
        addVec(0, '0, 1, 1, expv(1, DT, 5'd0, 5'd1, ISSUE, 0, 0));
        addVec(0, '0, 1, 1, expv(0, DT, 5'd0, 5'd1, HOLD,  0, 0));
        addVec(0, '0, 1, 1, expv(0, DT, 5'd0, 5'd1, IDLE,  0, 0));
        addVec(0, '0, 1, 1, expv(1, DB, 5'd0, 5'd0, ISSUE, 0, 0));
        addVec(0, '0, 1, 1, expv(0, DB, 5'd0, 5'd0, HOLD,  0, 0));
        addVec(0, '0, 1, 1, expv(0, DB, 5'd0, 5'd0, IDLE,  0, 0));
        // Three BE entries with the gate closed; opening it releases them every 3 cycles
        addVec(1, B1, 0, 1, expv(0, DB, 5'd0, 5'd1, IDLE,  0, 0));
        addVec(1, B2, 0, 1, expv(0, DB, 5'd0, 5'd2, IDLE,  0, 0));
        addVec(1, B3, 0, 1, expv(0, DB, 5'd0, 5'd3, IDLE,  0, 0));
        addVec(0, '0, 0, 1, expv(0, DB, 5'd0, 5'd3, IDLE,  0, 0));
        addVec(0, '0, 0, 1, expv(0, DB, 5'd0, 5'd3, IDLE,  0, 0));
        addVec(0, '0, 1, 1, expv(1, B1, 5'd0, 5'd2, ISSUE, 0, 0));
        addVec(0, '0, 1, 1, expv(0, B1, 5'd0, 5'd2, HOLD,  0, 0));
        addVec(0, '0, 1, 1, expv(0, B1, 5'd0, 5'd2, IDLE,  0, 0));
        addVec(0, '0, 1, 1, expv(1, B2, 5'd0, 5'd1, ISSUE, 0, 0));
        addVec(0, '0, 1, 1, expv(0, B2, 5'd0, 5'd1, HOLD,  0, 0));
        addVec(0, '0, 1, 1, expv(0, B2, 5'd0, 5'd1, IDLE,  0, 0));
        addVec(0, '0, 1, 1, expv(1, B3, 5'd0, 5'd0, ISSUE, 0, 0));
        addVec(0, '0, 0, 1, expv(0, B3, 5'd0, 5'd0, HOLD,  0, 0));
        addVec(0, '0, 1, 1, expv(0, B3, 5'd0, 5'd0, IDLE,  0, 0));

        $display("[TB] applying %0d table vectors", vecs.size());
        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Overflow: 17 TS writes with ready low, one discard pulse, then in-order drain
        for (int k = 0; k < 17; k++) begin
            tsExp[k][60:58] = 3'(k % 3);
            tsExp[k][57:0]  = 58'(k + 'hC000);
        end
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            descWrIn = 1'b1;
            descIn   = tsExp[k];
            beGate   = 1'b1;
            ready    = 1'b0;
            @(posedge clk);
            #1;
            if (k == 15) checkOutput("ts_full_no_drop", {tsCnt, tsDiscard}, {5'd16, 1'b0});
            if (k == 16) checkOutput("ts_drop_pulse", {tsCnt, tsDiscard}, {5'd16, 1'b1});
        end
        @(negedge clk);
        descWrIn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ts_drop_pulse_end", {tsCnt, tsDiscard}, {5'd16, 1'b0});
        @(negedge clk);
        ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            waitStrobe(found);
            checkOutput($sformatf("drain_strobe%0d", k), 76'(found), 76'(1'b1));
            if (found) checkOutput($sformatf("drain_desc%0d", k), 76'(descOut), 76'(tsExp[k]));
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (descWrOut) extra++;
        end
        checkOutput("drain_extra", 76'(extra), 76'(0));
        checkOutput("drain_empty", 76'(tsCnt), 76'(0));

        // Reset while in ISSUE with five entries still queued
        firstT6 = {3'h2, 58'h600};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            descWrIn = 1'b1;
            descIn   = (k == 5) ? {3'h3, 58'h6FF} : (firstT6 + 61'(k));
            ready    = 1'b0;
        end
        @(negedge clk);
        descWrIn = 1'b0;
        ready    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_issue", actual(), expv(1, firstT6, 5'd4, 5'd1, ISSUE, 0, 0));
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_reset", actual(), '0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("post_reset%0d", i), actual(), '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
